fdsti_range_coalesce: RTL and testbench
=======================================

FDSTI_RANGE_COALESCE -- requirements
Module: fdsti_range_coalesce

Interface
REQ-001 SHALL have parameter I_FDSSI_WIDTH, default 12, source-segment index width.
REQ-002 SHALL have parameter AWIDTH, default 32, address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, merged-entry count width.
REQ-004 SHALL have parameter TIMEOUT, default 64, idle cycles before forced emit; 0 disables.
REQ-005 SHALL use: clk  input  1  clock.
REQ-006 SHALL use: rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL use: s_addr_valid  input  1  input beat valid.
REQ-008 SHALL use: s_addr_ready  output  1  input beat accepted.
REQ-009 SHALL use: s_addr  input  I_FDSSI_WIDTH+2*AWIDTH  {fdssi, s_addr, e_addr}, fdssi in MSBs, e_addr in LSBs; matches one per-FDSTI FIFO output.
REQ-010 SHALL use: m_addr_valid  output  1  merged range valid.
REQ-011 SHALL use: m_addr_ready  input  1  downstream accept.
REQ-012 SHALL use: m_addr  output  I_FDSSI_WIDTH+2*AWIDTH  merged {fdssi, s_addr, e_addr}.
REQ-013 SHALL use: m_addr_cnt  output  CNT_WIDTH  number of input beats merged into m_addr.
REQ-014 SHALL use: flush  input  1  level request to emit all held data.
REQ-015 SHALL use: flush_done  output  1  one-cycle pulse when emptied after flush.
REQ-016 SHALL use: err_order  output  1  sticky flag, input beat with e_addr < s_addr seen.

Function
REQ-017 SHALL hold one pending range H (fdssi, s, e, cnt) and one output register O driving m_addr/m_addr_cnt/m_addr_valid.
REQ-018 SHALL implement states IDLE (H empty), HOLD (H full), FLUSH.
REQ-019 IDLE: s_addr_ready=1; accepted beat loads H with cnt=1, -> HOLD.
REQ-020 Beat is mergeable iff H full, same fdssi, beat.s == H.e+1 without overflow (H.e != all-ones), beat.e >= beat.s, H.cnt != all-ones.
REQ-021 HOLD, mergeable beat: s_addr_ready=1; H.e<=beat.e, H.cnt<=H.cnt+1; O untouched.
REQ-022 HOLD, non-mergeable beat: s_addr_ready = !m_addr_valid || m_addr_ready; on accept O<=H, m_addr_valid<=1, H<=beat with cnt=1.
REQ-023 Malformed beat (e < s): SHALL set err_order, be non-mergeable, and be passed through as its own range with cnt=1.
REQ-024 Idle counter SHALL reset on every accepted beat and increment in HOLD otherwise; at TIMEOUT with O free (empty or m_addr_ready), O<=H, -> IDLE.
REQ-025 flush asserted: SHALL take priority over s_addr_valid in the same cycle; s_addr_ready=0; state -> FLUSH.
REQ-026 FLUSH: moves H to O once O free; when H and O both empty, flush_done pulses one cycle, -> IDLE; flush held high re-enters FLUSH only if H refills (cannot, ready=0), so no repeat pulse until flush deasserts and reasserts.
REQ-027 flush in IDLE with O empty: flush_done SHALL pulse the next cycle.
REQ-028 m_addr/m_addr_cnt SHALL be stable while m_addr_valid=1 and m_addr_ready=0.
REQ-029 Latency: O valid one cycle after the triggering event (non-mergeable accept, timeout, flush move).
REQ-030 Output order SHALL equal input order; no beat lost or duplicated; sum of m_addr_cnt equals accepted beats.

Reset
REQ-031 On rst: state IDLE, H empty, m_addr_valid=0, m_addr=0, m_addr_cnt=0, flush_done=0, err_order=0, idle counter 0.
REQ-032 Reset mid-operation SHALL discard H and O contents without emitting.

Structure
REQ-033 AWIDTH, I_FDSSI_WIDTH and the {fdssi,s_addr,e_addr} field offsets SHALL live in the shared address-info package used by the FDSSI/FDSTI FIFO stages.
REQ-034 State encoding constants SHALL be local to the module.
REQ-035 One sub-module is natural: fdsti_range_match (combinational mergeability check, REQ-020/023).

Verification
REQ-036 Beats (fdssi 3, 0x100-0x10F), (3, 0x110-0x11F), (3, 0x120-0x12F), flush -> one output (3, 0x100, 0x12F), cnt=3, then flush_done.
REQ-037 Beats (3, 0x100-0x10F), (4, 0x110-0x11F) -> two outputs, cnt=1 each, order preserved.
REQ-038 H.e=0xFFFFFFFF then beat (same fdssi, s=0x0) -> no merge, two outputs.
REQ-039 m_addr_ready=0 for 10 cycles with non-mergeable traffic -> s_addr_ready drops, m_addr stable, no loss.
REQ-040 Single beat, no further input, TIMEOUT=64 -> output appears 65 cycles after accept; beat (5, 0x20-0x10) -> err_order=1, passed unmerged.
REQ-041 rst asserted while HOLD and O full -> all outputs zero next edge, no emission after release.

Source files
------------

// File: rtl/fdsti_range_coalesce_pkg.sv
// Shared address-info layout for the FDSSI/FDSTI FIFO stages.
// A beat is {fdssi, s_addr, e_addr} with e_addr in the LSBs.
package fdsti_range_coalesce_pkg;

  localparam int AWIDTH_DEF        = 32;
  localparam int I_FDSSI_WIDTH_DEF = 12;
  localparam int E_LSB             = 0;

  function automatic int s_lsb(input int aw);
    return aw;
  endfunction

  function automatic int f_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int info_width(input int fw, input int aw);
    return fw + 2 * aw;
  endfunction

endpackage

// File: rtl/fdsti_range_match.sv
// Decides whether an incoming beat extends the held range.
// Malformed ranges (e < s) never merge, in either direction.
module fdsti_range_match
  import fdsti_range_coalesce_pkg::*;
#(
  parameter int I_FDSSI_WIDTH = I_FDSSI_WIDTH_DEF,
  parameter int AWIDTH        = AWIDTH_DEF,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     h_vld_i,
  input  logic [I_FDSSI_WIDTH-1:0] h_fdssi_i,
  input  logic [AWIDTH-1:0]        h_s_i,
  input  logic [AWIDTH-1:0]        h_e_i,
  input  logic [CNT_WIDTH-1:0]     h_cnt_i,
  input  logic [I_FDSSI_WIDTH-1:0] b_fdssi_i,
  input  logic [AWIDTH-1:0]        b_s_i,
  input  logic [AWIDTH-1:0]        b_e_i,
  output logic                     merge_o,
  output logic                     malformed_o
);

  always_comb begin
    malformed_o = (b_e_i < b_s_i);
    // h_e_i != all-ones guarantees the +1 below cannot wrap
    merge_o = h_vld_i
           && (h_fdssi_i == b_fdssi_i)
           && (h_e_i != '1)
           && (b_s_i == h_e_i + 1'b1)
           && !malformed_o
           && (h_e_i >= h_s_i)
           && (h_cnt_i != '1);
  end

endmodule

// File: rtl/fdsti_range_coalesce.sv
// Coalesces contiguous {fdssi, s, e} address ranges from one FDSTI FIFO
// into merged ranges, with idle timeout and level-sensitive flush.
//
// state    | meaning
// ST_IDLE  | holding register empty, accepting beats
// ST_HOLD  | holding register full, merging or emitting on break
// ST_FLUSH | draining holding and output registers, input stalled
module fdsti_range_coalesce
  import fdsti_range_coalesce_pkg::*;
#(
  parameter int I_FDSSI_WIDTH = I_FDSSI_WIDTH_DEF,
  parameter int AWIDTH        = AWIDTH_DEF,
  parameter int CNT_WIDTH     = 8,
  parameter int TIMEOUT       = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_addr_valid,
  output logic                              s_addr_ready,
  input  logic [I_FDSSI_WIDTH+2*AWIDTH-1:0] s_addr,
  output logic                              m_addr_valid,
  input  logic                              m_addr_ready,
  output logic [I_FDSSI_WIDTH+2*AWIDTH-1:0] m_addr,
  output logic [CNT_WIDTH-1:0]              m_addr_cnt,
  input  logic                              flush,
  output logic                              flush_done,
  output logic                              err_order
);

  localparam int IW    = info_width(I_FDSSI_WIDTH, AWIDTH);
  localparam int S_LSB = s_lsb(AWIDTH);
  localparam int F_LSB = f_lsb(AWIDTH);
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_FLUSH} state_t;

  state_t                   state_q, state_d;
  logic                     h_vld_q, h_vld_d;
  logic [I_FDSSI_WIDTH-1:0] h_fdssi_q, h_fdssi_d;
  logic [AWIDTH-1:0]        h_s_q, h_s_d, h_e_q, h_e_d;
  logic [CNT_WIDTH-1:0]     h_cnt_q, h_cnt_d;
  logic [IW-1:0]            o_q, o_d;
  logic [CNT_WIDTH-1:0]     o_cnt_q, o_cnt_d;
  logic                     o_vld_q, o_vld_d;
  logic [TW-1:0]            idle_q, idle_d;
  logic                     err_q, err_d;
  logic                     done_q, done_d;

  logic [I_FDSSI_WIDTH-1:0] b_fdssi;
  logic [AWIDTH-1:0]        b_s, b_e;
  logic                     merge, malformed, o_free, accept, load_o;

  assign b_fdssi = s_addr[F_LSB +: I_FDSSI_WIDTH];
  assign b_s     = s_addr[S_LSB +: AWIDTH];
  assign b_e     = s_addr[E_LSB +: AWIDTH];

  fdsti_range_match #(
    .I_FDSSI_WIDTH(I_FDSSI_WIDTH),
    .AWIDTH       (AWIDTH),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_match (
    .h_vld_i    (h_vld_q),
    .h_fdssi_i  (h_fdssi_q),
    .h_s_i      (h_s_q),
    .h_e_i      (h_e_q),
    .h_cnt_i    (h_cnt_q),
    .b_fdssi_i  (b_fdssi),
    .b_s_i      (b_s),
    .b_e_i      (b_e),
    .merge_o    (merge),
    .malformed_o(malformed)
  );

  always_comb begin
    state_d      = state_q;
    h_vld_d      = h_vld_q;
    h_fdssi_d    = h_fdssi_q;
    h_s_d        = h_s_q;
    h_e_d        = h_e_q;
    h_cnt_d      = h_cnt_q;
    o_d          = o_q;
    o_cnt_d      = o_cnt_q;
    o_vld_d      = o_vld_q;
    idle_d       = '0;
    err_d        = err_q;
    s_addr_ready = 1'b0;
    flush_done   = 1'b0;
    load_o       = 1'b0;
    o_free       = !o_vld_q || m_addr_ready;

    if (o_vld_q && m_addr_ready) o_vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flush && !done_q) state_d = ST_FLUSH;
        else if (!flush)      s_addr_ready = 1'b1;
      end
      ST_HOLD: begin
        if (flush) state_d = ST_FLUSH;
        else       s_addr_ready = merge || o_free;
      end
      ST_FLUSH: begin
        if (h_vld_q) begin
          if (o_free) begin
            load_o  = 1'b1;
            h_vld_d = 1'b0;
          end
        end else if (!o_vld_q) begin
          flush_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    accept = s_addr_valid && s_addr_ready;

    if (accept) begin
      if (malformed) err_d = 1'b1;
      if (merge) begin
        h_e_d   = b_e;
        h_cnt_d = h_cnt_q + 1'b1;
      end else begin
        load_o    = h_vld_q;
        h_vld_d   = 1'b1;
        h_fdssi_d = b_fdssi;
        h_s_d     = b_s;
        h_e_d     = b_e;
        h_cnt_d   = CNT_WIDTH'(1);
        state_d   = ST_HOLD;
      end
    end else if (state_q == ST_HOLD && !flush) begin
      // counter saturates at TIMEOUT and waits there for the output slot
      idle_d = (idle_q != TO_VAL) ? idle_q + 1'b1 : idle_q;
      if (TIMEOUT != 0 && idle_q == TO_VAL && o_free) begin
        load_o  = 1'b1;
        h_vld_d = 1'b0;
        idle_d  = '0;
        state_d = ST_IDLE;
      end
    end

    if (load_o) begin
      o_d     = {h_fdssi_q, h_s_q, h_e_q};
      o_cnt_d = h_cnt_q;
      o_vld_d = 1'b1;
    end

    // blocks re-entry into flush until the request is dropped
    done_d = flush && (flush_done || done_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      h_vld_q   <= 1'b0;
      h_fdssi_q <= '0;
      h_s_q     <= '0;
      h_e_q     <= '0;
      h_cnt_q   <= '0;
      o_q       <= '0;
      o_cnt_q   <= '0;
      o_vld_q   <= 1'b0;
      idle_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_vld_q   <= h_vld_d;
      h_fdssi_q <= h_fdssi_d;
      h_s_q     <= h_s_d;
      h_e_q     <= h_e_d;
      h_cnt_q   <= h_cnt_d;
      o_q       <= o_d;
      o_cnt_q   <= o_cnt_d;
      o_vld_q   <= o_vld_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign m_addr       = o_q;
  assign m_addr_cnt   = o_cnt_q;
  assign m_addr_valid = o_vld_q;
  assign err_order    = err_q;

endmodule

// File: tb/tb_fdsti_range_coalesce.sv
// Directed bench for fdsti_range_coalesce: merge, break, overflow, stall,
// timeout, malformed beats, flush pulses and mid-operation reset.
module tb_fdsti_range_coalesce;

  localparam int FW = 12;
  localparam int AW = 32;
  localparam int CW = 8;
  localparam int IW = FW + 2 * AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_addr_valid = 1'b0;
  logic          s_addr_ready;
  logic [IW-1:0] s_addr = '0;
  logic          m_addr_valid;
  logic          m_addr_ready = 1'b0;
  logic [IW-1:0] m_addr;
  logic [CW-1:0] m_addr_cnt;
  logic          flush = 1'b0;
  logic          flush_done;
  logic          err_order;

  always #5 clk = ~clk;

  fdsti_range_coalesce #(
    .I_FDSSI_WIDTH(FW), .AWIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT(64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_addr_valid(s_addr_valid),
    .s_addr_ready(s_addr_ready),
    .s_addr      (s_addr),
    .m_addr_valid(m_addr_valid),
    .m_addr_ready(m_addr_ready),
    .m_addr      (m_addr),
    .m_addr_cnt  (m_addr_cnt),
    .flush       (flush),
    .flush_done  (flush_done),
    .err_order   (err_order)
  );

  typedef struct packed {
    logic [IW-1:0] a;
    logic [CW-1:0] c;
  } beat_t;

  beat_t q[$];
  int    done_cnt = 0;
  int    n_assert = 0;
  int    n_fail   = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_addr_valid && m_addr_ready) q.push_back('{a: m_addr, c: m_addr_cnt});
      if (flush_done) done_cnt++;
    end
  end

  function automatic logic [IW-1:0] pk(input logic [FW-1:0] f,
                                       input logic [AW-1:0] s,
                                       input logic [AW-1:0] e);
    return {f, s, e};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [FW-1:0] f, input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic ok;
    ok = 1'b0;
    s_addr_valid = 1'b1;
    s_addr = pk(f, s, e);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (s_addr_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    s_addr_valid = 1'b0;
    chk("send_accept", 128'(ok), 128'd1);
  endtask

  task automatic do_flush();
    int  d0;
    logic ok;
    d0 = done_cnt;
    ok = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt > d0) ok = 1'b1;
    end
    chk("flush_done_seen", 128'(ok), 128'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("flush_single_pulse", 128'(done_cnt), 128'(d0 + 1));
    flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag, input logic [FW-1:0] f, input logic [AW-1:0] s,
                         input logic [AW-1:0] e, input logic [CW-1:0] c);
    beat_t b;
    chk({tag, "_present"}, 128'(q.size() != 0), 128'd1);
    if (q.size() != 0) begin
      b = q.pop_front();
      chk({tag, "_addr"}, 128'(b.a), 128'(pk(f, s, e)));
      chk({tag, "_cnt"}, 128'(b.c), 128'(c));
    end
  endtask

  initial begin
    int lat;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 128'(m_addr_valid), 128'd0);
    chk("rst_m_addr", 128'(m_addr), 128'd0);
    chk("rst_m_cnt", 128'(m_addr_cnt), 128'd0);
    chk("rst_flush_done", 128'(flush_done), 128'd0);
    chk("rst_err_order", 128'(err_order), 128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", 128'(s_addr_ready), 128'd1);
    m_addr_ready = 1'b1;

    // contiguous run merges into one range
    send(12'd3, 32'h100, 32'h10F);
    send(12'd3, 32'h110, 32'h11F);
    send(12'd3, 32'h120, 32'h12F);
    do_flush();
    chk("merge_qsize", 128'(q.size()), 128'd1);
    pop_chk("merge3", 12'd3, 32'h100, 32'h12F, 8'd3);

    // fdssi change breaks the run
    send(12'd3, 32'h100, 32'h10F);
    send(12'd4, 32'h110, 32'h11F);
    do_flush();
    chk("fdssi_qsize", 128'(q.size()), 128'd2);
    pop_chk("fdssi_a", 12'd3, 32'h100, 32'h10F, 8'd1);
    pop_chk("fdssi_b", 12'd4, 32'h110, 32'h11F, 8'd1);

    // end address at all-ones must not wrap into s=0
    send(12'd3, 32'hFFFF_FF00, 32'hFFFF_FFFF);
    send(12'd3, 32'h0, 32'hF);
    do_flush();
    chk("wrap_qsize", 128'(q.size()), 128'd2);
    pop_chk("wrap_a", 12'd3, 32'hFFFF_FF00, 32'hFFFF_FFFF, 8'd1);
    pop_chk("wrap_b", 12'd3, 32'h0, 32'hF, 8'd1);

    // downstream stall with non-mergeable traffic
    m_addr_ready = 1'b0;
    send(12'd1, 32'h0, 32'hF);
    send(12'd2, 32'h10, 32'h1F);
    s_addr_valid = 1'b1;
    s_addr = pk(12'd3, 32'h20, 32'h2F);
    repeat (10) begin
      @(negedge clk);
      chk("stall_ready", 128'(s_addr_ready), 128'd0);
      chk("stall_m_addr", 128'(m_addr), 128'(pk(12'd1, 32'h0, 32'hF)));
      chk("stall_m_valid", 128'(m_addr_valid), 128'd1);
    end
    @(posedge clk);
    #1;
    m_addr_ready = 1'b1;
    send(12'd3, 32'h20, 32'h2F);
    send(12'd4, 32'h30, 32'h3F);
    do_flush();
    chk("stall_qsize", 128'(q.size()), 128'd4);
    pop_chk("stall_a", 12'd1, 32'h0, 32'hF, 8'd1);
    pop_chk("stall_b", 12'd2, 32'h10, 32'h1F, 8'd1);
    pop_chk("stall_c", 12'd3, 32'h20, 32'h2F, 8'd1);
    pop_chk("stall_d", 12'd4, 32'h30, 32'h3F, 8'd1);

    // idle timeout emits a lone beat
    send(12'd7, 32'h40, 32'h4F);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (m_addr_valid) begin
        lat = k;
        break;
      end
    end
    chk("timeout_latency", 128'(lat), 128'd65);
    @(posedge clk);
    #1;
    chk("timeout_qsize", 128'(q.size()), 128'd1);
    pop_chk("timeout", 12'd7, 32'h40, 32'h4F, 8'd1);

    // malformed beat flags and passes through unmerged
    chk("err_before", 128'(err_order), 128'd0);
    send(12'd5, 32'h20, 32'h10);
    chk("err_set", 128'(err_order), 128'd1);
    send(12'd5, 32'h11, 32'h1F);
    do_flush();
    chk("mal_qsize", 128'(q.size()), 128'd2);
    pop_chk("mal_a", 12'd5, 32'h20, 32'h10, 8'd1);
    pop_chk("mal_b", 12'd5, 32'h11, 32'h1F, 8'd1);
    chk("err_sticky", 128'(err_order), 128'd1);

    // flush while empty pulses once on the following cycle
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_flush_pulse", 128'(flush_done), 128'd1);
    @(posedge clk);
    #1;
    chk("idle_flush_pulse_end", 128'(flush_done), 128'd0);
    chk("flush_blocks_ready", 128'(s_addr_ready), 128'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_flush_no_repeat", 128'(flush_done), 128'd0);
    flush = 1'b0;
    @(posedge clk);
    #1;

    // reset with both registers full discards everything
    m_addr_ready = 1'b0;
    send(12'd8, 32'h0, 32'hF);
    send(12'd9, 32'h10, 32'h1F);
    chk("pre_rst_valid", 128'(m_addr_valid), 128'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 128'(m_addr_valid), 128'd0);
    chk("mid_rst_addr", 128'(m_addr), 128'd0);
    chk("mid_rst_cnt", 128'(m_addr_cnt), 128'd0);
    chk("mid_rst_err", 128'(err_order), 128'd0);
    chk("mid_rst_done", 128'(flush_done), 128'd0);
    rst = 1'b0;
    m_addr_ready = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("post_rst_no_emit", 128'(q.size()), 128'd0);
    chk("post_rst_valid", 128'(m_addr_valid), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
